// File: rtl/framebuffer_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_write_arbiter_if
// Description : Bundles the three buses of the framebuffer write arbiter:
//               - the CPU pixel write channel (valid/ready), with its
//                 address-error pulse;
//               - the fill-engine command channel (start/base/length/colour),
//                 with its busy and done status;
//               - the registered framebuffer write port.
//               Signal names keep their arbiter-relative direction prefixes
//               (i_ = into the arbiter, o_ = out of the arbiter).
//               Modports:
//               - slave  : the arbiter side.
//               - master : the requester / framebuffer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface framebuffer_write_arbiter_if #(
  parameter int BITS_PER_PIXEL = 3
);
  // CPU pixel write channel
  logic                      i_Cpu_Write_Valid;
  logic [31:0]               i_Cpu_Write_Addr;
  logic [BITS_PER_PIXEL-1:0] i_Cpu_Write_Data;
  logic                      o_Cpu_Write_Ready;
  logic                      o_Cpu_Addr_Error;

  // Fill engine command channel
  logic                      i_Fill_Start;
  logic [31:0]               i_Fill_Base;
  logic [31:0]               i_Fill_Length;
  logic [BITS_PER_PIXEL-1:0] i_Fill_Color;
  logic                      o_Fill_Busy;
  logic                      o_Fill_Done;

  // Framebuffer write port
  logic                      o_Fb_Write_Enable;
  logic [31:0]               o_Fb_Write_Addr;
  logic [BITS_PER_PIXEL-1:0] o_Fb_Write_Data;

  modport slave (
    input  i_Cpu_Write_Valid, i_Cpu_Write_Addr, i_Cpu_Write_Data,
    input  i_Fill_Start, i_Fill_Base, i_Fill_Length, i_Fill_Color,
    output o_Cpu_Write_Ready, o_Cpu_Addr_Error,
    output o_Fill_Busy, o_Fill_Done,
    output o_Fb_Write_Enable, o_Fb_Write_Addr, o_Fb_Write_Data
  );

  modport master (
    output i_Cpu_Write_Valid, i_Cpu_Write_Addr, i_Cpu_Write_Data,
    output i_Fill_Start, i_Fill_Base, i_Fill_Length, i_Fill_Color,
    input  o_Cpu_Write_Ready, o_Cpu_Addr_Error,
    input  o_Fill_Busy, o_Fill_Done,
    input  o_Fb_Write_Enable, o_Fb_Write_Addr, o_Fb_Write_Data
  );
endinterface
`default_nettype wire

// File: rtl/framebuffer_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_write_arbiter
// Description : Owns the single framebuffer write port and shares it between
//               CPU pixel writes and a hardware fill engine that paints a
//               contiguous pixel range with one colour. While a fill runs the
//               two requesters alternate (fill first), so each gets at least
//               half the bandwidth. Writes outside 0..FRAMEBUFFER_DEPTH-1 are
//               dropped before reaching the RAM.
// Ports       : i_Clock  - clock, all logic on posedge
//               i_Reset  - asynchronous active-high reset
//               bus      - framebuffer_write_arbiter_if.slave:
//                          * CPU valid/ready write channel + address-error pulse
//                          * fill command (start/base/length/colour),
//                            busy and done status
//                          * registered framebuffer write enable/addr/data
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_write_arbiter #(
  parameter int BITS_PER_PIXEL    = 3,
  parameter int FRAMEBUFFER_DEPTH = 640 * 480
) (
  input  wire logic                   i_Clock,
  input  wire logic                   i_Reset,
  framebuffer_write_arbiter_if.slave  bus
);

  localparam logic [1:0]  c_STATE_IDLE = 2'd0;
  localparam logic [1:0]  c_STATE_FILL = 2'd1;
  localparam logic [1:0]  c_STATE_DONE = 2'd2;

  localparam logic [32:0] c_DEPTH = 33'(FRAMEBUFFER_DEPTH);

  logic [1:0]                r_State;
  logic                      r_Cpu_Turn;
  logic [31:0]               r_Count;
  logic [31:0]               r_Base;
  logic [31:0]               r_Length;
  logic [BITS_PER_PIXEL-1:0] r_Color;

  logic                      r_Fb_We;
  logic [31:0]               r_Fb_Addr;
  logic [BITS_PER_PIXEL-1:0] r_Fb_Data;
  logic                      r_Addr_Err;

  logic [32:0] w_Fill_Addr;
  logic        w_Fill_In_Range;
  logic        w_Cpu_In_Range;
  logic        w_Cpu_Ready;
  logic        w_Cpu_Issue;
  logic        w_Fill_Issue;
  logic        w_Fill_Last;

  // 33-bit sum so a base near 2^32 cannot wrap back into the valid range.
  assign w_Fill_Addr     = {1'b0, r_Base} + {1'b0, r_Count};
  assign w_Fill_In_Range = (w_Fill_Addr < c_DEPTH);
  assign w_Cpu_In_Range  = ({1'b0, bus.i_Cpu_Write_Addr} < c_DEPTH);

  // Ready comes from state only, never from valid.
  assign w_Cpu_Ready  = (r_State == c_STATE_FILL) ? r_Cpu_Turn : 1'b1;
  assign w_Cpu_Issue  = bus.i_Cpu_Write_Valid && w_Cpu_Ready;
  // The fill engine takes every FILL cycle the CPU does not use.
  assign w_Fill_Issue = (r_State == c_STATE_FILL) && !w_Cpu_Issue;
  assign w_Fill_Last  = w_Fill_Issue && (r_Count == (r_Length - 32'd1));

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State    <= c_STATE_IDLE;
      r_Cpu_Turn <= 1'b0;
      r_Count    <= 32'd0;
      r_Base     <= 32'd0;
      r_Length   <= 32'd0;
      r_Color    <= '0;
    end else begin
      case (r_State)
        c_STATE_IDLE: begin
          if (bus.i_Fill_Start) begin
            r_Base     <= bus.i_Fill_Base;
            r_Length   <= bus.i_Fill_Length;
            r_Color    <= bus.i_Fill_Color;
            r_Count    <= 32'd0;
            r_Cpu_Turn <= 1'b0;
            r_State    <= (bus.i_Fill_Length == 32'd0) ? c_STATE_DONE : c_STATE_FILL;
          end
        end
        c_STATE_FILL: begin
          if (w_Cpu_Issue) begin
            r_Cpu_Turn <= 1'b0;
          end else begin
            r_Count    <= r_Count + 32'd1;
            r_Cpu_Turn <= 1'b1;
            if (w_Fill_Last) begin
              r_State <= c_STATE_DONE;
            end
          end
        end
        c_STATE_DONE: begin
          r_State <= c_STATE_IDLE;
        end
        default: begin
          r_State <= c_STATE_IDLE;
        end
      endcase
    end
  end

  // Registered write port. Address/data only move on a real write so the
  // RAM-side bus stays quiet on idle and clipped cycles.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Fb_We    <= 1'b0;
      r_Fb_Addr  <= 32'd0;
      r_Fb_Data  <= '0;
      r_Addr_Err <= 1'b0;
    end else begin
      r_Fb_We    <= (w_Cpu_Issue && w_Cpu_In_Range) || (w_Fill_Issue && w_Fill_In_Range);
      r_Addr_Err <= w_Cpu_Issue && !w_Cpu_In_Range;
      if (w_Cpu_Issue && w_Cpu_In_Range) begin
        r_Fb_Addr <= bus.i_Cpu_Write_Addr;
        r_Fb_Data <= bus.i_Cpu_Write_Data;
      end else if (w_Fill_Issue && w_Fill_In_Range) begin
        r_Fb_Addr <= w_Fill_Addr[31:0];
        r_Fb_Data <= r_Color;
      end
    end
  end

  assign bus.o_Cpu_Write_Ready = w_Cpu_Ready;
  assign bus.o_Cpu_Addr_Error  = r_Addr_Err;
  assign bus.o_Fill_Busy       = (r_State == c_STATE_FILL);
  assign bus.o_Fill_Done       = (r_State == c_STATE_DONE);
  assign bus.o_Fb_Write_Enable = r_Fb_We;
  assign bus.o_Fb_Write_Addr   = r_Fb_Addr;
  assign bus.o_Fb_Write_Data   = r_Fb_Data;

endmodule
`default_nettype wire
